// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared types and constants for the Wishbone round-robin arbiter.
//   arb_state_e  - arbiter FSM state (idle / bus owned)
//   CTI_*/BTE_*  - Wishbone registered-feedback cycle/burst type codes
//   WD_W         - watchdog counter width
package wb_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } arb_state_e;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_WRAP4   = 2'b01;
  localparam logic [1:0] BTE_WRAP8   = 2'b10;
  localparam logic [1:0] BTE_WRAP16  = 2'b11;

  localparam int unsigned WD_W = 16;

endpackage

// File: rtl/wb_arb_rr_pick.sv
// wb_arb_rr_pick: combinational round-robin picker.
//   req        - request vector, one bit per master
//   last_owner - index of the most recent owner; search starts at last_owner+1
//   grant      - one-hot winner (zero when nobody requests)
//   valid      - at least one request present
module wb_arb_rr_pick
  import wb_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned IW          = 1
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IW-1:0]          last_owner,
  output logic [NUM_MASTERS-1:0] grant,
  output logic                   valid
);

  // Walk offsets 1..N from last_owner; first requester at the smallest offset wins.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    for (int unsigned i = 1; i <= NUM_MASTERS; i++) begin
      for (int unsigned j = 0; j < NUM_MASTERS; j++) begin
        if (!valid && req[j] && (((32'(last_owner) + i) % NUM_MASTERS) == j)) begin
          grant[j] = 1'b1;
          valid    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/wb_arb_rr.sv
// wb_arb_rr: round-robin arbiter, NUM_MASTERS Wishbone masters onto one slave.
//   wb_clk_i/wb_rst_i - clock, synchronous active-low reset
//   wbm_*_i           - flattened master requests, master m in slice m
//   wbm_rdt_o         - slave read data broadcast to every slice
//   wbm_ack/err/rty_o - responses, routed only to the granted master
//   wbs_*_o / wbs_*_i - slave request / response
//   grant_o           - registered one-hot owner, zero while idle
// Optional build macro WB_ARB_WATCHDOG_EN: terminate unanswered strobes with
// an error after TIMEOUT cycles.
module wb_arb_rr
  import wb_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned AW          = 32,
  parameter int unsigned DW          = 32,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic [NUM_MASTERS*AW-1:0]     wbm_adr_i,
  input  logic [NUM_MASTERS*DW-1:0]     wbm_dat_i,
  input  logic [NUM_MASTERS*(DW/8)-1:0] wbm_sel_i,
  input  logic [NUM_MASTERS-1:0]        wbm_we_i,
  input  logic [NUM_MASTERS-1:0]        wbm_cyc_i,
  input  logic [NUM_MASTERS-1:0]        wbm_stb_i,
  input  logic [NUM_MASTERS*3-1:0]      wbm_cti_i,
  input  logic [NUM_MASTERS*2-1:0]      wbm_bte_i,
  output logic [NUM_MASTERS*DW-1:0]     wbm_rdt_o,
  output logic [NUM_MASTERS-1:0]        wbm_ack_o,
  output logic [NUM_MASTERS-1:0]        wbm_err_o,
  output logic [NUM_MASTERS-1:0]        wbm_rty_o,
  output logic [AW-1:0]                 wbs_adr_o,
  output logic [DW-1:0]                 wbs_dat_o,
  output logic [DW/8-1:0]               wbs_sel_o,
  output logic                          wbs_we_o,
  output logic                          wbs_cyc_o,
  output logic                          wbs_stb_o,
  output logic [2:0]                    wbs_cti_o,
  output logic [1:0]                    wbs_bte_o,
  input  logic [DW-1:0]                 wbs_rdt_i,
  input  logic                          wbs_ack_i,
  input  logic                          wbs_err_i,
  input  logic                          wbs_rty_i,
  output logic [NUM_MASTERS-1:0]        grant_o
);

  localparam int unsigned IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int unsigned SW = DW / 8;

  arb_state_e             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IW-1:0]          last_q, last_d;
  logic [IW-1:0]          owner_idx;
  logic [NUM_MASTERS-1:0] pick_grant;
  logic                   pick_valid;
  logic                   owned, cyc_g, stb_g, resp_any, timeout;

  wb_arb_rr_pick #(
    .NUM_MASTERS (NUM_MASTERS),
    .IW          (IW)
  ) u_pick (
    .req        (wbm_cyc_i),
    .last_owner (last_q),
    .grant      (pick_grant),
    .valid      (pick_valid)
  );

  assign owned    = (state_q == ST_OWNED);
  assign cyc_g    = |(wbm_cyc_i & grant_q);
  assign stb_g    = |(wbm_stb_i & grant_q);
  assign resp_any = wbs_ack_i | wbs_err_i | wbs_rty_i;
  assign grant_o  = grant_q;

  // One-hot grant to index, remembered as last owner on release.
  always_comb begin
    owner_idx = '0;
    for (int unsigned j = 0; j < NUM_MASTERS; j++) begin
      if (grant_q[j]) owner_idx = IW'(j);
    end
  end

`ifdef WB_ARB_WATCHDOG_EN
  logic [WD_W-1:0] wd_q, wd_d;

  assign timeout = owned && (wd_q == WD_W'(TIMEOUT));

  // Count strobed cycles without any slave response; expiry clears it.
  always_comb begin
    wd_d = wd_q;
    if (!owned || !cyc_g || timeout || resp_any) wd_d = '0;
    else if (stb_g)                              wd_d = wd_q + WD_W'(1);
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) wd_q <= '0;
    else           wd_q <= wd_d;
  end
`else
  logic [15:0] unused_timeout;
  assign unused_timeout = 16'(TIMEOUT);
  assign timeout        = 1'b0;
`endif

  // State register.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= IW'(NUM_MASTERS - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  // Next state: grant on any request in IDLE, release when owner drops cyc.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d = ST_OWNED;
          grant_d = pick_grant;
        end
      end
      ST_OWNED: begin
        if (!cyc_g) begin
          state_d = ST_IDLE;
          grant_d = '0;
          last_d  = owner_idx;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // Request mux from the granted slice; everything quiet while idle.
  always_comb begin
    wbs_adr_o = '0;
    wbs_dat_o = '0;
    wbs_sel_o = '0;
    wbs_we_o  = 1'b0;
    wbs_cti_o = '0;
    wbs_bte_o = '0;
    if (owned) begin
      for (int unsigned j = 0; j < NUM_MASTERS; j++) begin
        if (grant_q[j]) begin
          wbs_adr_o = wbm_adr_i[j*AW +: AW];
          wbs_dat_o = wbm_dat_i[j*DW +: DW];
          wbs_sel_o = wbm_sel_i[j*SW +: SW];
          wbs_we_o  = wbm_we_i[j];
          wbs_cti_o = wbm_cti_i[j*3 +: 3];
          wbs_bte_o = wbm_bte_i[j*2 +: 2];
        end
      end
    end
  end

  assign wbs_cyc_o = owned & cyc_g;
  assign wbs_stb_o = owned & stb_g & ~timeout;

  assign wbm_rdt_o = {NUM_MASTERS{wbs_rdt_i}};
  assign wbm_ack_o = owned ? (grant_q & {NUM_MASTERS{wbs_ack_i}})           : '0;
  assign wbm_err_o = owned ? (grant_q & {NUM_MASTERS{wbs_err_i | timeout}}) : '0;
  assign wbm_rty_o = owned ? (grant_q & {NUM_MASTERS{wbs_rty_i}})           : '0;

endmodule

// File: tb/tb_wb_arb_rr.sv
// tb_wb_arb_rr: self-checking bench for wb_arb_rr (4 masters, TIMEOUT=16).
// A transaction-level model (owner index or none, last owner, stall count)
// predicts every output each cycle; directed tables and sequences cover the
// handover, burst, rotation, reset and watchdog corner cases.
module tb_wb_arb_rr;
  import wb_arb_pkg::*;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 16;
`ifdef WB_ARB_WATCHDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N*AW-1:0] wbm_adr;
  logic [N*DW-1:0] wbm_dat;
  logic [N*SW-1:0] wbm_sel;
  logic [N-1:0]    wbm_we, wbm_cyc, wbm_stb;
  logic [N*3-1:0]  wbm_cti;
  logic [N*2-1:0]  wbm_bte;
  logic [N*DW-1:0] wbm_rdt;
  logic [N-1:0]    wbm_ack, wbm_err, wbm_rty, grant;
  logic [AW-1:0]   wbs_adr;
  logic [DW-1:0]   wbs_dat, wbs_rdt;
  logic [SW-1:0]   wbs_sel;
  logic            wbs_we, wbs_cyc, wbs_stb, wbs_ack, wbs_err, wbs_rty;
  logic [2:0]      wbs_cti;
  logic [1:0]      wbs_bte;

  int checks   = 0;
  int failures = 0;

  // Reference model state: owner index (-1 = bus free), last owner, stall count.
  int m_owner = -1;
  int m_last  = N - 1;
  int m_wd    = 0;

  always #5 clk = ~clk;

  wb_arb_rr #(
    .NUM_MASTERS (N),
    .AW          (AW),
    .DW          (DW),
    .TIMEOUT     (TO)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst_n),
    .wbm_adr_i (wbm_adr),
    .wbm_dat_i (wbm_dat),
    .wbm_sel_i (wbm_sel),
    .wbm_we_i  (wbm_we),
    .wbm_cyc_i (wbm_cyc),
    .wbm_stb_i (wbm_stb),
    .wbm_cti_i (wbm_cti),
    .wbm_bte_i (wbm_bte),
    .wbm_rdt_o (wbm_rdt),
    .wbm_ack_o (wbm_ack),
    .wbm_err_o (wbm_err),
    .wbm_rty_o (wbm_rty),
    .wbs_adr_o (wbs_adr),
    .wbs_dat_o (wbs_dat),
    .wbs_sel_o (wbs_sel),
    .wbs_we_o  (wbs_we),
    .wbs_cyc_o (wbs_cyc),
    .wbs_stb_o (wbs_stb),
    .wbs_cti_o (wbs_cti),
    .wbs_bte_o (wbs_bte),
    .wbs_rdt_i (wbs_rdt),
    .wbs_ack_i (wbs_ack),
    .wbs_err_i (wbs_err),
    .wbs_rty_i (wbs_rty),
    .grant_o   (grant)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] req, input int last);
    for (int i = 1; i <= N; i++) begin
      int k;
      k = (last + i) % N;
      if (req[k]) return k;
    end
    return -1;
  endfunction

  // Advance the model with the inputs present at the clock edge.
  task automatic model_update();
    if (!rst_n) begin
      m_owner = -1;
      m_last  = N - 1;
      m_wd    = 0;
    end else if (m_owner < 0) begin
      m_wd = 0;
      if (wbm_cyc != '0) m_owner = rr_pick(wbm_cyc, m_last);
    end else if (!wbm_cyc[m_owner]) begin
      m_last  = m_owner;
      m_owner = -1;
      m_wd    = 0;
    end else if (WD_EN && m_wd == TO) begin
      m_wd = 0;
    end else if (wbs_ack || wbs_err || wbs_rty) begin
      m_wd = 0;
    end else if (wbm_stb[m_owner]) begin
      m_wd = m_wd + 1;
    end
  endtask

  task automatic check_all();
    logic [N-1:0] e_grant, e_ack, e_err, e_rty;
    logic [AW-1:0] e_adr;
    logic [DW-1:0] e_dat;
    logic [SW-1:0] e_sel;
    logic [2:0] e_cti;
    logic [1:0] e_bte;
    logic e_we, e_cyc, e_stb, e_to;
    bit own;
    own = (m_owner >= 0);
    e_to = WD_EN && own && (m_wd == TO);
    e_grant = '0; e_ack = '0; e_err = '0; e_rty = '0;
    e_adr = '0; e_dat = '0; e_sel = '0; e_cti = '0; e_bte = '0;
    e_we = 1'b0; e_cyc = 1'b0; e_stb = 1'b0;
    if (own) begin
      e_grant[m_owner] = 1'b1;
      e_ack[m_owner]   = wbs_ack;
      e_err[m_owner]   = wbs_err | e_to;
      e_rty[m_owner]   = wbs_rty;
      e_adr = wbm_adr[m_owner*AW +: AW];
      e_dat = wbm_dat[m_owner*DW +: DW];
      e_sel = wbm_sel[m_owner*SW +: SW];
      e_cti = wbm_cti[m_owner*3 +: 3];
      e_bte = wbm_bte[m_owner*2 +: 2];
      e_we  = wbm_we[m_owner];
      e_cyc = wbm_cyc[m_owner];
      e_stb = wbm_stb[m_owner] & ~e_to;
    end
    chk("grant", grant, e_grant);
    chk("wbs_cyc", wbs_cyc, e_cyc);
    chk("wbs_stb", wbs_stb, e_stb);
    chk("wbs_adr", wbs_adr, e_adr);
    chk("wbs_dat", wbs_dat, e_dat);
    chk("wbs_sel", wbs_sel, e_sel);
    chk("wbs_we", wbs_we, e_we);
    chk("wbs_cti", wbs_cti, e_cti);
    chk("wbs_bte", wbs_bte, e_bte);
    chk("ack_o", wbm_ack, e_ack);
    chk("err_o", wbm_err, e_err);
    chk("rty_o", wbm_rty, e_rty);
    chk("rdt_o", wbm_rdt, {N{wbs_rdt}});
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  task automatic set_req(input logic [N-1:0] c);
    wbm_cyc = c;
    wbm_stb = c;
  endtask

  typedef struct {
    logic       rst_n;
    logic [3:0] cyc;
    logic       ack;
    logic [3:0] e_grant;
    logic       e_cyc;
    logic [3:0] e_ack;
  } vec_t;

  vec_t tbl[12];

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int errs, first, guard, idx;

    rst_n = 1'b0;
    wbm_adr = '0; wbm_dat = '0; wbm_sel = '0; wbm_we = '0;
    wbm_cyc = '0; wbm_stb = '0; wbm_cti = '0; wbm_bte = '0;
    wbs_rdt = '0; wbs_ack = 1'b0; wbs_err = 1'b0; wbs_rty = 1'b0;
    for (int m = 0; m < N; m++) begin
      wbm_adr[m*AW +: AW] = 32'h1000 * (m + 1);
      wbm_dat[m*DW +: DW] = 32'hA000_0000 + m;
    end

    // Handover, dead cycle and no-preemption table.
    tbl[0]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000};
    tbl[1]  = '{1'b1, 4'b0011, 1'b0, 4'b0001, 1'b1, 4'b0000};
    tbl[2]  = '{1'b1, 4'b0011, 1'b1, 4'b0001, 1'b1, 4'b0001};
    tbl[3]  = '{1'b1, 4'b0010, 1'b0, 4'b0000, 1'b0, 4'b0000};
    tbl[4]  = '{1'b1, 4'b0010, 1'b0, 4'b0010, 1'b1, 4'b0000};
    tbl[5]  = '{1'b1, 4'b0010, 1'b1, 4'b0010, 1'b1, 4'b0010};
    tbl[6]  = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000};
    tbl[7]  = '{1'b1, 4'b0100, 1'b0, 4'b0100, 1'b1, 4'b0000};
    tbl[8]  = '{1'b1, 4'b0101, 1'b1, 4'b0100, 1'b1, 4'b0100};
    tbl[9]  = '{1'b1, 4'b0001, 1'b0, 4'b0000, 1'b0, 4'b0000};
    tbl[10] = '{1'b1, 4'b0001, 1'b0, 4'b0001, 1'b1, 4'b0000};
    tbl[11] = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000};
    for (int i = 0; i < 12; i++) begin
      rst_n   = tbl[i].rst_n;
      set_req(tbl[i].cyc);
      wbs_ack = tbl[i].ack;
      step();
      chk($sformatf("tbl%0d_grant", i), grant, tbl[i].e_grant);
      chk($sformatf("tbl%0d_cyc", i), wbs_cyc, tbl[i].e_cyc);
      chk($sformatf("tbl%0d_ack", i), wbm_ack, tbl[i].e_ack);
    end

    // Master 1 INCR burst while master 0 keeps requesting.
    set_req(4'b0011);
    wbm_adr[0 +: AW] = 32'h200;
    step();
    chk("burst_grant", grant, 4'b0010);
    for (int b = 0; b < 4; b++) begin
      wbm_adr[1*AW +: AW] = 32'h100 + 32'(4 * b);
      wbm_cti[1*3 +: 3]   = (b < 3) ? CTI_INCR : CTI_EOB;
      wbm_bte[1*2 +: 2]   = BTE_LINEAR;
      wbs_ack = 1'b1;
      #1;
      chk($sformatf("burst%0d_ack", b), wbm_ack, 4'b0010);
      chk($sformatf("burst%0d_adr", b), wbs_adr, 32'h100 + 32'(4 * b));
      chk($sformatf("burst%0d_cti", b), wbs_cti, (b < 3) ? CTI_INCR : CTI_EOB);
      step();
      chk($sformatf("burst%0d_hold", b), grant, 4'b0010);
    end
    wbs_ack = 1'b0;
    set_req(4'b0001);
    step();
    chk("burst_dead", wbs_cyc, 1'b0);
    step();
    chk("burst_next", grant, 4'b0001);
    set_req(4'b0000);
    step();

    // Reset during beat 2 of a burst.
    set_req(4'b0010);
    step();
    chk("rst_burst_grant", grant, 4'b0010);
    wbs_ack = 1'b1;
    step();
    step();
    rst_n = 1'b0;
    step();
    chk("rst_mid_cyc", wbs_cyc, 1'b0);
    chk("rst_mid_ack", wbm_ack, 4'b0000);
    rst_n = 1'b1;
    wbs_ack = 1'b0;
    set_req(4'b0011);
    step();
    chk("rst_first", grant, 4'b0001);
    set_req(4'b0000);
    step();
    step();

    // All four masters requesting, one-beat transfers.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    set_req(4'b1111);
    for (int k = 0; k < 6; k++) begin
      step();
      guard = 0;
      while (grant == '0 && guard < 8) begin
        step();
        guard++;
      end
      chk($sformatf("rot%0d", k), grant, 4'(1) << (k % 4));
      idx = rr_pick(grant, N - 1);
      if (idx < 0) idx = 0;
      wbs_ack = 1'b1;
      step();
      wbs_ack = 1'b0;
      wbm_cyc[idx] = 1'b0;
      wbm_stb[idx] = 1'b0;
      step();
      wbm_cyc[idx] = 1'b1;
      wbm_stb[idx] = 1'b1;
    end
    set_req(4'b0000);
    step();

    // Silent slave.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    set_req(4'b0001);
    step();
    chk("wd_grant", grant, 4'b0001);
    errs = 0;
    first = -1;
    for (int s = 1; s <= 40; s++) begin
      step();
      if (wbm_err[0]) begin
        errs++;
        if (first < 0) first = s;
      end
    end
`ifdef WB_ARB_WATCHDOG_EN
    chk("wd_first", 32'(first), 32'(16));
    chk("wd_count", 32'(errs), 32'(2));
`else
    chk("wd_none", 32'(errs), 32'(0));
`endif
    set_req(4'b0000);
    step();

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      int r;
      rst_n = ($urandom_range(0, 99) != 0);
      for (int m = 0; m < N; m++) begin
        if (wbm_cyc[m]) begin
          if ($urandom_range(0, 5) == 0) wbm_cyc[m] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          wbm_cyc[m] = 1'b1;
        end
        wbm_stb[m] = wbm_cyc[m] & ($urandom_range(0, 3) != 0);
        wbm_we[m]  = 1'($urandom_range(0, 1));
        wbm_adr[m*AW +: AW] = $urandom;
        wbm_dat[m*DW +: DW] = $urandom;
        wbm_sel[m*SW +: SW] = 4'($urandom_range(0, 15));
        wbm_cti[m*3 +: 3]   = 3'($urandom_range(0, 7));
        wbm_bte[m*2 +: 2]   = 2'($urandom_range(0, 3));
      end
      r = $urandom_range(0, 9);
      wbs_ack = (r < 3);
      wbs_err = (r == 3);
      wbs_rty = (r == 4);
      wbs_rdt = $urandom;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_arb_rr.md
WB_ARB_RR -- requirements
Module: wb_arb_rr

Interface
REQ-001 Parameter NUM_MASTERS, default 2; number of Wishbone master ports, legal range 1..8.
REQ-002 Parameter AW, default 32; address width.
REQ-003 Parameter DW, default 32; data width, multiple of 8, sel width DW/8.
REQ-004 Parameter TIMEOUT, default 255; watchdog limit in cycles, legal range 1..65535.
REQ-005 wb_clk_i  in  1  sole clock; all logic rising-edge.
REQ-006 wb_rst_i  in  1  reset, synchronous, active-low.
REQ-007 wbm_adr_i/dat_i/sel_i/we_i/cyc_i/stb_i/cti_i/bte_i  in  NUM_MASTERS x (AW/DW/DW/8/1/1/1/3/2)  master requests; master m occupies slice m.
REQ-008 wbm_rdt_o  out  NUM_MASTERS*DW  read data, slave rdt broadcast to all slices.
REQ-009 wbm_ack_o/err_o/rty_o  out  NUM_MASTERS each  per-master responses.
REQ-010 wbs_adr_o/dat_o/sel_o/we_o/cyc_o/stb_o/cti_o/bte_o  out  AW/DW/DW/8/1/1/1/3/2  slave request.
REQ-011 wbs_rdt_i/ack_i/err_i/rty_i  in  DW/1/1/1  slave response.
REQ-012 grant_o  out  NUM_MASTERS  one-hot current owner, all-zero when idle.

Function
REQ-013 FSM states IDLE and OWNED only.
REQ-014 IDLE: when any wbm_cyc_i is high, the arbiter registers a grant to the first requester found round-robin starting at last_owner+1 (mod NUM_MASTERS) and moves to OWNED; arbitration latency is exactly 1 cycle.
REQ-015 OWNED: wbs_* request fields are combinationally muxed from the granted slice; wbs_cyc_o = cyc_i[g], wbs_stb_o = stb_i[g].
REQ-016 In OWNED, ack/err/rty of the granted master are routed from the slave combinationally; every non-granted master sees 0.
REQ-017 Grant persists while cyc_i[g] stays high, covering classic cycles and incrementing/wrapping bursts irrespective of cti/bte.
REQ-018 When cyc_i[g] falls, the FSM returns to IDLE the next cycle, last_owner <= g, and wbs_cyc_o/wbs_stb_o are 0 in that cycle (one dead cycle per handover).
REQ-019 Requests arriving while OWNED are ignored until the return to IDLE; no preemption.
REQ-020 With all NUM_MASTERS requesting continuously, grants rotate 0,1,...,N-1,0 with no master skipped.
REQ-021 NUM_MASTERS=1: same FSM; dead cycle between owner sessions still applies.
REQ-022 In IDLE, all wbs_* request outputs are 0 and all wbm ack/err/rty are 0.

Reset
REQ-023 While wb_rst_i=0 at a clock edge: state <= IDLE, grant_o <= 0, last_owner <= NUM_MASTERS-1 (master 0 wins first), watchdog <= 0.
REQ-024 Reset asserted mid-transfer drops wbs_cyc_o/wbs_stb_o to 0 at the following edge; no response is forwarded after it.

Configuration
REQ-025 Macro WB_ARB_WATCHDOG_EN: when defined, a 16-bit counter increments each OWNED cycle with wbs_stb_o=1 and no slave ack/err/rty, and clears on any response or on leaving OWNED.
REQ-026 When the counter reaches TIMEOUT, err_o[g] is driven 1 for exactly one cycle, wbs_stb_o is forced 0 in that cycle, and the counter clears.
REQ-027 Without WB_ARB_WATCHDOG_EN, no counter exists and a non-responding slave stalls the owner indefinitely.

Structure
REQ-028 Package wb_arb_pkg holds the FSM state enum, the CTI constants (CLASSIC 3'b000, INCR 3'b010, EOB 3'b111) and the BTE constants.
REQ-029 Sub-module wb_arb_rr_pick: combinational round-robin picker (request vector, last_owner) -> one-hot grant plus valid.

Verification
REQ-030 After reset release, masters 0 and 1 request in the same cycle -> grant_o=2'b01 one cycle later; master 1 granted after the cycle following master 0's cyc fall.
REQ-031 Master 1 4-beat INCR burst (cti 010,010,010,111) at 0x100 -> four slave acks all on ack_o[1], ack_o[0]=0 throughout, grant unchanged.
REQ-032 NUM_MASTERS=4, all requesting continuously, one-beat transfers -> grant sequence 0,1,2,3,0,1.
REQ-033 Reset pulled low during beat 2 of a burst -> wbs_cyc_o=0 next edge; after release, master 0 is granted first.
REQ-034 WB_ARB_WATCHDOG_EN, TIMEOUT=16, slave never acks -> err_o[g]=1 for one cycle after 16 unanswered stb cycles; without the macro, no err ever.
